// File: rtl/mac_array_seq.sv
// Windowed reader over three lane-packed operand memories feeding LANES independent
// multiply-add lanes: element mode streams A*B+C, dot mode returns C[first] + sum(A*B).
module mac_array_seq #(
  parameter int LANES = 10,
  parameter int DW    = 8,
  parameter int DEPTH = 10,
  parameter int AW    = $clog2(DEPTH),
  parameter int ACC_W = 2*DW + $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   mode,
  input  logic [AW-1:0]          base_addr,
  input  logic [AW:0]            len,
  output logic                   mem_en,
  output logic [AW-1:0]          mem_addr,
  input  logic [LANES*DW-1:0]    a_rdata,
  input  logic [LANES*DW-1:0]    b_rdata,
  input  logic [LANES*DW-1:0]    c_rdata,
  output logic [LANES*ACC_W-1:0] res,
  output logic                   res_valid,
  output logic                   res_last,
  output logic                   busy,
  output logic                   done
);

  localparam int EW = 2*DW + 1;
  localparam logic [AW:0]   ONE_L  = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_A  = AW'(1);
  localparam logic [AW-1:0] LAST_A = AW'(DEPTH-1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t state_reg, state_next;

  logic              mode_reg;
  logic [AW:0]       len_reg;
  logic [AW:0]       cnt_reg;
  logic [AW-1:0]     addr_reg;
  logic              accept;
  logic              issue_last;

  logic              rd_v_reg, rd_first_reg, rd_last_reg;
  logic              s1_v_reg, s1_first_reg, s1_last_reg;
  logic [LANES*DW-1:0] a_s1_reg, b_s1_reg, c_s1_reg;
  logic              res_valid_reg, res_last_reg;

  assign accept     = (state_reg == IDLE) && start && (len != '0);
  assign issue_last = (cnt_reg == len_reg - ONE_L);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = (len == '0) ? DONE : RUN;
      RUN:     if (issue_last) state_next = DRAIN;
      DRAIN:   if (res_valid_reg && res_last_reg) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_en = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (state_reg)
      RUN:     begin mem_en = 1'b1; busy = 1'b1; end
      DRAIN:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign mem_addr  = addr_reg;
  assign res_valid = res_valid_reg;
  assign res_last  = res_last_reg;

  // Job parameters are frozen at accept; the address walks the window with wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_reg <= 1'b0;
      len_reg  <= '0;
      cnt_reg  <= '0;
      addr_reg <= '0;
    end else if (accept) begin
      mode_reg <= mode;
      len_reg  <= len;
      cnt_reg  <= '0;
      addr_reg <= base_addr;
    end else if (state_reg == RUN) begin
      cnt_reg  <= cnt_reg + ONE_L;
      addr_reg <= (addr_reg == LAST_A) ? '0 : addr_reg + ONE_A;
    end
  end

  // Tags travel alongside the data: memory output stage, then operand stage, then result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_v_reg      <= 1'b0;
      rd_first_reg  <= 1'b0;
      rd_last_reg   <= 1'b0;
      s1_v_reg      <= 1'b0;
      s1_first_reg  <= 1'b0;
      s1_last_reg   <= 1'b0;
      a_s1_reg      <= '0;
      b_s1_reg      <= '0;
      c_s1_reg      <= '0;
      res_valid_reg <= 1'b0;
      res_last_reg  <= 1'b0;
    end else begin
      rd_v_reg      <= mem_en;
      rd_first_reg  <= mem_en && (cnt_reg == '0);
      rd_last_reg   <= mem_en && issue_last;
      s1_v_reg      <= rd_v_reg;
      s1_first_reg  <= rd_first_reg;
      s1_last_reg   <= rd_last_reg;
      if (rd_v_reg) begin
        a_s1_reg <= a_rdata;
        b_s1_reg <= b_rdata;
        c_s1_reg <= c_rdata;
      end
      res_valid_reg <= s1_v_reg && (!mode_reg || s1_last_reg);
      res_last_reg  <= s1_v_reg && s1_last_reg;
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [DW-1:0]    a_l, b_l, c_l;
    logic [2*DW-1:0]  prod;
    logic [EW-1:0]    elem;
    logic [ACC_W-1:0] acc_next;
    logic [ACC_W-1:0] acc_reg;
    logic [ACC_W-1:0] res_reg;

    assign a_l  = a_s1_reg[gi*DW +: DW];
    assign b_l  = b_s1_reg[gi*DW +: DW];
    assign c_l  = c_s1_reg[gi*DW +: DW];
    assign prod = (2*DW)'(a_l) * (2*DW)'(b_l);
    assign elem = EW'(prod) + EW'(c_l);
    // C only seeds the first element of a dot product.
    assign acc_next = s1_first_reg ? ACC_W'(elem) : acc_reg + ACC_W'(prod);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        acc_reg <= '0;
        res_reg <= '0;
      end else if (s1_v_reg) begin
        acc_reg <= acc_next;
        if (!mode_reg)        res_reg <= ACC_W'(elem);
        else if (s1_last_reg) res_reg <= acc_next;
      end
    end

    assign res[gi*ACC_W +: ACC_W] = res_reg;
  end

endmodule

// File: tb/tb_mac_array_seq.sv
// Scoreboard bench for mac_array_seq: jobs push expected addresses/results from a plain
// arithmetic model; a negedge monitor pops and compares whenever the DUT issues or emits.
module tb_mac_array_seq;
  localparam int LANES = 2;
  localparam int DW    = 8;
  localparam int DEPTH = 10;
  localparam int AW    = $clog2(DEPTH);
  localparam int ACC_W = 2*DW + $clog2(DEPTH) + 1;

  logic                   clk = 1'b0;
  logic                   reset_n = 1'b0;
  logic                   start = 1'b0;
  logic                   mode = 1'b0;
  logic [AW-1:0]          base_addr = '0;
  logic [AW:0]            len = '0;
  logic                   mem_en;
  logic [AW-1:0]          mem_addr;
  logic [LANES*DW-1:0]    a_rdata = '0, b_rdata = '0, c_rdata = '0;
  logic [LANES*ACC_W-1:0] res;
  logic                   res_valid, res_last, busy, done;

  mac_array_seq #(.LANES(LANES), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
    .base_addr(base_addr), .len(len), .mem_en(mem_en), .mem_addr(mem_addr),
    .a_rdata(a_rdata), .b_rdata(b_rdata), .c_rdata(c_rdata),
    .res(res), .res_valid(res_valid), .res_last(res_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [LANES*DW-1:0] mem_a [DEPTH];
  logic [LANES*DW-1:0] mem_b [DEPTH];
  logic [LANES*DW-1:0] mem_c [DEPTH];

  always @(posedge clk) begin
    if (mem_en) begin
      a_rdata <= mem_a[mem_addr];
      b_rdata <= mem_b[mem_addr];
      c_rdata <= mem_c[mem_addr];
    end
  end

  typedef struct {
    logic [LANES*ACC_W-1:0] res;
    bit                     last;
    int                     n_iss;
  } exp_t;

  exp_t exp_q[$];
  int   iss_q[$];
  int   addr_q[$];

  int cyc = 0;
  int nchecks = 0;
  int nerrors = 0;
  int en_count = 0;
  int last_res_cyc = -100;
  logic [LANES*ACC_W-1:0] last_res_val = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    nchecks++;
    if (got !== expv) begin
      nerrors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  task automatic fail(input string name);
    nchecks++;
    nerrors++;
    $display("FAIL %s: event not expected (cycle %0d)", name, cyc);
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (mem_en) begin
        en_count++;
        iss_q.push_back(cyc);
        if (addr_q.size() == 0) fail("unexpected_mem_en");
        else chk("mem_addr", 64'(mem_addr), 64'(addr_q.pop_front()));
      end
      if (res_last && !res_valid) fail("res_last_without_valid");
      if (res_valid) begin
        if (exp_q.size() == 0) fail("unexpected_res_valid");
        else begin
          exp_t e;
          int   ic;
          e = exp_q.pop_front();
          chk("res", 64'(res), 64'(e.res));
          chk("res_last", 64'(res_last), 64'(e.last));
          ic = -100;
          for (int k = 0; k < e.n_iss; k++)
            if (iss_q.size() > 0) ic = iss_q.pop_front();
          chk("latency", 64'(cyc - ic), 64'(3));
          $display("res   cycle=%0d lane0=%0d lane1=%0d last=%0b", cyc,
                   res[0 +: ACC_W], res[ACC_W +: ACC_W], res_last);
          if (res_last) last_res_cyc = cyc;
          last_res_val = res;
        end
      end
    end
  end

  // Reference: per element address (base+i) mod DEPTH, lane value A*B+C or C[first]+sum(A*B).
  task automatic push_expected(input bit md, input int base, input int ln);
    exp_t e;
    longint sum [LANES];
    for (int i = 0; i < ln; i++) begin
      int ad;
      logic [LANES*DW-1:0] wa, wb, wc;
      ad = (base + i) % DEPTH;
      addr_q.push_back(ad);
      wa = mem_a[ad];
      wb = mem_b[ad];
      wc = mem_c[ad];
      e.res = '0;
      for (int k = 0; k < LANES; k++) begin
        longint p;
        p = longint'(wa[k*DW +: DW]) * longint'(wb[k*DW +: DW]);
        if (md == 1'b0 || i == 0) sum[k] = p + longint'(wc[k*DW +: DW]);
        else                      sum[k] = sum[k] + p;
        e.res[k*ACC_W +: ACC_W] = ACC_W'(sum[k]);
      end
      if (md == 1'b0) begin
        e.last  = (i == ln - 1);
        e.n_iss = 1;
        exp_q.push_back(e);
      end else if (i == ln - 1) begin
        e.last  = 1'b1;
        e.n_iss = ln;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic run_job(input bit md, input int base, input int ln, input bit poke);
    int  t0;
    bit  seen;
    en_count = 0;
    push_expected(md, base, ln);
    $display("job   mode=%0d base=%0d len=%0d poke=%0d", md, base, ln, poke);
    @(negedge clk);
    mode = md; base_addr = AW'(base); len = (AW+1)'(ln); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    chk("busy_after_start", 64'(busy), 64'(ln != 0));
    if (poke && ln != 0) begin
      len = (AW+1)'(1); mode = ~md; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (done) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    if (!seen) fail("done_timeout");
    else begin
      if (ln == 0) chk("done_len0_cycle", 64'(cyc), 64'(t0));
      else         chk("done_after_last_res", 64'(cyc), 64'(last_res_cyc + 1));
      chk("busy_at_done", 64'(busy), 64'(0));
      chk("issue_count", 64'(en_count), 64'(ln));
    end
    @(negedge clk);
    chk("done_pulse_width", 64'(done), 64'(0));
    chk("scoreboard_empty", 64'(exp_q.size() + addr_q.size()), 64'(0));
  endtask

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++)
      for (int k = 0; k < LANES; k++) begin
        mem_a[i][k*DW +: DW] = DW'($urandom_range(0, 255));
        mem_b[i][k*DW +: DW] = DW'($urandom_range(0, 255));
        mem_c[i][k*DW +: DW] = DW'($urandom_range(0, 255));
      end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_mem_en"}, 64'(mem_en), 64'(0));
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
    chk({tag, "_res"}, 64'(res), 64'(0));
    chk({tag, "_res_valid"}, 64'(res_valid), 64'(0));
    chk({tag, "_res_last"}, 64'(res_last), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    fill_random();
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("in_reset");
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_mem_en", 64'(mem_en), 64'(0));
      chk("idle_busy", 64'(busy), 64'(0));
      chk("idle_res_valid", 64'(res_valid), 64'(0));
    end
    check_outputs_zero("idle");

    for (int i = 0; i < 3; i++) begin
      mem_a[i][0 +: DW] = DW'(i + 1);
      mem_b[i][0 +: DW] = DW'(i + 4);
      mem_c[i][0 +: DW] = DW'(i + 7);
    end
    run_job(1'b0, 0, 3, 1'b0);
    chk("elem_last_lane0", 64'(last_res_val[0 +: ACC_W]), 64'(27));
    run_job(1'b1, 0, 3, 1'b1);
    chk("dot_lane0", 64'(last_res_val[0 +: ACC_W]), 64'(39));

    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = '1; mem_b[i] = '1; mem_c[i] = '1;
    end
    run_job(1'b1, 0, DEPTH, 1'b0);
    chk("dot_max_lane0", 64'(last_res_val[0 +: ACC_W]), 64'(650505));
    chk("dot_max_lane1", 64'(last_res_val[ACC_W +: ACC_W]), 64'(650505));

    fill_random();
    run_job(1'b0, 8, 4, 1'b0);
    run_job(1'b1, 8, 4, 1'b0);
    run_job(1'b0, 5, 0, 1'b0);
    run_job(1'b1, 3, 1, 1'b1);

    // Abort mid-RUN after two issues.
    en_count = 0;
    push_expected(1'b0, 2, 8);
    @(negedge clk);
    mode = 1'b0; base_addr = AW'(2); len = (AW+1)'(8); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (en_count >= 2) break;
      @(negedge clk);
    end
    chk("abort_issue_count", 64'(en_count), 64'(2));
    #1 reset_n = 1'b0;
    #1 check_outputs_zero("abort");
    exp_q.delete(); iss_q.delete(); addr_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", 64'(done), 64'(0));
    end
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_abort_done", 64'(done), 64'(0));
    chk("post_abort_busy", 64'(busy), 64'(0));
    run_job(1'b0, 2, 8, 1'b0);

    for (int j = 0; j < 25; j++) begin
      fill_random();
      run_job(1'($urandom_range(0, 1)), $urandom_range(0, DEPTH-1),
              $urandom_range(0, DEPTH), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
    $finish;
  end
endmodule
